mod_mult_seq: RTL and testbench
===============================

Name: mod_mult_seq

Overview:
- Sequential modular multiplier, z = (x * y) mod MODULUS, for the 4-bit modulo-11 arithmetic datapath.
- Sits downstream of the modular adder/subtractor stage. It consumes in-range residues and produces an in-range residue.
- Uses MSB-first double-and-add over the bits of y. Each step uses one combinational modular-add core.
- Start/busy/done handshake. Latency is fixed and independent of the data.

Parameters:
- MODULUS, 11: modulus M; must satisfy 2 <= M <= 2**WIDTH.
- WIDTH, 4: operand and result width in bits.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- start  in  1  request; sampled only when the block can accept (IDLE or DONE state)
- x  in  WIDTH  multiplicand residue; captured when start is accepted
- y  in  WIDTH  multiplier residue; captured when start is accepted
- busy  out  1  high while a multiplication is in progress
- done  out  1  one-cycle pulse; z valid that cycle
- z  out  WIDTH  result; holds its value until the next done
- err  out  1  operand-range error, valid with done (see Optional Feature)

Behaviour:
- Reset, applied on any cycle including mid-operation:
  - state=IDLE; busy=0, done=0, err=0, z=0.
  - Internal accumulator, operand and bit-counter registers cleared.
- States: IDLE, DBL, ADD, DONE.
- IDLE:
  - If start=1: capture x and y; acc=0; bit index i=WIDTH-1; go to DBL.
  - Otherwise stay in IDLE.
- DBL: acc <= (acc + acc) mod M; go to ADD.
- ADD:
  - acc <= (acc + (y[i] ? x : 0)) mod M.
  - If i==0, go to DONE. Otherwise decrement i and go to DBL.
- DONE:
  - done=1 and z=acc, registered. z keeps this value until the next done.
  - If start=1 in this cycle, it is accepted as in IDLE (back-to-back operation); otherwise go to IDLE.
- Latency: start sampled at edge k -> busy=1 over cycles k+1 .. k+2*WIDTH -> done=1 in cycle k+2*WIDTH+1. For WIDTH=4, done arrives 9 cycles after the accepting edge.
- busy is registered, and is high exactly in the DBL and ADD states.
- start is ignored during DBL and ADD: no restart, and captured operands are unchanged.
- Modular add, given a, b < M: s = a + b computed at WIDTH+1 bits; result = (s >= M) ? s - M : s. The result is always < M. No wider intermediates are allowed.
- acc < M is invariant after every state update.
- Inputs x and y are don't-care except at the accepting edge.

Optional Feature:
- Macro: MOD_MULT_RANGE_CHECK_EN.
- Defined:
  - At acceptance, if x >= M or y >= M: skip computation and go directly to DONE on the next edge.
  - That DONE cycle has done=1, err=1, z=0; latency is 1 cycle.
  - Valid operands give err=0 alongside done.
- Undefined:
  - No comparison logic; err is tied to 0.
  - Out-of-range operands are processed unchanged, and the result is unspecified.
  - Benches must not drive out-of-range operands in this configuration.

Decomposition:
- Shared package mod_arith_pkg holds:
  - constants MODULUS=11 and WIDTH=4;
  - the state typedef (IDLE, DBL, ADD, DONE);
  - the residue type logic [WIDTH-1:0].
- One sub-module: mod_add_core, combinational (a + b) mod M parameterised by MODULUS and WIDTH. It is instantiated once and shared between DBL and ADD through an operand mux.

Test Plan:
- Basic product: rst for 2 cycles, then start with x=3, y=7 -> busy high for 8 cycles, done pulse 9 cycles after the accepting edge with z=10 (21 mod 11); z holds 10 afterwards.
- Extremes: x=10, y=10 -> z=1 (100 mod 11). x=0, y=9 -> z=0. x=1, y=10 -> z=10. err=0 in all cases.
- Start while busy: start x=4, y=5; pulse start with x=2, y=2 in cycle 3 -> ignored; z=9 (20 mod 11) at the original done time; a single done pulse.
- Back-to-back and reset: start in the DONE cycle with x=6, y=6 -> a second done 9 cycles later with z=3. Separately, assert rst in cycle 4 of an operation -> busy=0, done=0, z=0 next cycle, and no done pulse follows.
- Range check (macro defined): x=12, y=3 -> done and err both high one cycle after acceptance, z=0. Then x=5, y=2 -> z=10, err=0.
- Exhaustive: all 121 pairs with x, y in 0..10, compared against (x*y)%11. Report the match count; 121/121 is required.

Source files
------------

// File: rtl/mod_arith_pkg.sv
// Shared definitions for the 4-bit modulo-11 arithmetic datapath.
// Contents: modulus/width constants, multiplier FSM state type, residue type.
package mod_arith_pkg;

    localparam int unsigned MODULUS = 11;
    localparam int unsigned WIDTH   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DBL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef logic [WIDTH-1:0] residue_t;

endpackage : mod_arith_pkg

// File: rtl/mod_add_core.sv
// Combinational modular adder: sum_o = (a_i + b_i) mod MODULUS.
// Ports:
//   a_i, b_i : WIDTH-bit residues, both assumed < MODULUS
//   sum_o    : WIDTH-bit residue, always < MODULUS
module mod_add_core
    import mod_arith_pkg::*;
#(
    parameter int unsigned MODULUS = mod_arith_pkg::MODULUS,
    parameter int unsigned WIDTH   = mod_arith_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);

    localparam int unsigned SW = WIDTH + 1;

    logic [SW-1:0] raw_sum;
    logic [SW-1:0] mod_val;

    // One carry bit is enough: a + b < 2*M <= 2**(WIDTH+1).
    assign mod_val = SW'(MODULUS);
    assign raw_sum = SW'(a_i) + SW'(b_i);
    assign sum_o   = (raw_sum >= mod_val) ? WIDTH'(raw_sum - mod_val) : WIDTH'(raw_sum);

endmodule : mod_add_core

// File: rtl/mod_mult_seq.sv
// Sequential modular multiplier z = (x * y) mod MODULUS, MSB-first double-and-add.
// One shared mod_add_core serves both the double (DBL) and add (ADD) steps.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   start    : request, accepted in IDLE or DONE
//   x, y     : operand residues, captured on acceptance
//   busy     : high in DBL/ADD
//   done     : one-cycle pulse, z valid
//   z        : result, held until the next done
//   err      : operand range error (only with MOD_MULT_RANGE_CHECK_EN defined)
// Optional feature macro: MOD_MULT_RANGE_CHECK_EN
module mod_mult_seq
    import mod_arith_pkg::*;
#(
    parameter int unsigned MODULUS = mod_arith_pkg::MODULUS,
    parameter int unsigned WIDTH   = mod_arith_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z,
    output logic             err
);

    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q,   acc_d;
    logic [WIDTH-1:0]   x_q,     x_d;
    logic [WIDTH-1:0]   y_q,     y_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
    logic [WIDTH-1:0]   z_q,     z_d;
    logic               err_q,   err_d;

    logic [WIDTH-1:0]   add_a_c;
    logic [WIDTH-1:0]   add_b_c;
    logic [WIDTH-1:0]   add_sum_c;
    logic               range_bad_c;

    // Operand range check on the live inputs at the accepting edge.
`ifdef MOD_MULT_RANGE_CHECK_EN
    assign range_bad_c = ((WIDTH+1)'(x) >= (WIDTH+1)'(MODULUS)) ||
                         ((WIDTH+1)'(y) >= (WIDTH+1)'(MODULUS));
`else
    assign range_bad_c = 1'b0;
`endif

    // Operand mux for the shared adder: acc+acc in DBL, acc+(y[i]?x:0) in ADD.
    always_comb begin
        add_a_c = acc_q;
        add_b_c = '0;
        unique case (state_q)
            DBL:     add_b_c = acc_q;
            ADD:     add_b_c = y_q[idx_q] ? x_q : '0;
            default: add_b_c = '0;
        endcase
    end

    mod_add_core #(
        .MODULUS (MODULUS),
        .WIDTH   (WIDTH)
    ) u_add (
        .a_i   (add_a_c),
        .b_i   (add_b_c),
        .sum_o (add_sum_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        x_d     = x_q;
        y_d     = y_q;
        idx_d   = idx_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        z_d     = z_q;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    x_d   = x;
                    y_d   = y;
                    acc_d = '0;
                    idx_d = IDX_W'(WIDTH - 1);
                    if (range_bad_c) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        z_d     = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = DBL;
                        busy_d  = 1'b1;
                    end
                end
            end
            DBL: begin
                acc_d   = add_sum_c;
                state_d = ADD;
                busy_d  = 1'b1;
            end
            ADD: begin
                acc_d = add_sum_c;
                if (idx_q == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    z_d     = add_sum_c;
                end else begin
                    idx_d   = idx_q - IDX_W'(1);
                    state_d = DBL;
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            z_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            z_q     <= z_d;
            err_q   <= err_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign z    = z_q;
    assign err  = err_q;

endmodule : mod_mult_seq

// File: tb/tb_mod_mult_seq.sv
// Scoreboard bench for mod_mult_seq: the driver pushes expected {err,z} on each
// accepted start; a monitor pops and compares on every done pulse.
module tb_mod_mult_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] x;
    logic [3:0] y;
    logic       busy;
    logic       done;
    logic [3:0] z;
    logic       err;

    int total = 0;
    int bad   = 0;
    int matched = 0;

    logic [4:0] exp_q[$];
    logic [4:0] mon_e;

    always #5 clk = ~clk;

    mod_mult_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .y     (y),
        .busy  (busy),
        .done  (done),
        .z     (z),
        .err   (err)
    );

    function automatic void check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("z", int'(z), int'(mon_e[3:0]));
                check("err", int'(err), int'(mon_e[4]));
                if (z == mon_e[3:0] && err == mon_e[4]) matched++;
            end
        end
    end

    // Present a start at the current (post-negedge) time; accepted on the next edge.
    task automatic issue(input logic [3:0] xi, input logic [3:0] yi,
                         input logic [3:0] ez, input logic ee);
        exp_q.push_back({ee, ez});
        start = 1'b1;
        x     = xi;
        y     = yi;
        @(posedge clk);
        #1;
        start = 1'b0;
        x     = 4'($urandom);
        y     = 4'($urandom);
    endtask

    // Count negedges until done; lat=9 means done nine cycles after acceptance.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (busy) bcnt++;
            if (done) break;
        end
        check("done_seen", int'(done), 1);
    endtask

    int lat, bcnt, m0;
    int ex_x[3] = '{10, 0, 1};
    int ex_y[3] = '{10, 9, 10};
    int ex_z[3] = '{1, 0, 10};

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_z", int'(z), 0);
        check("rst_err", int'(err), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic product 3*7 = 21 -> 10
        issue(4'd3, 4'd7, 4'd10, 1'b0);
        wait_done(lat, bcnt);
        check("basic_latency", lat, 9);
        check("basic_busy_cycles", bcnt, 8);
        @(negedge clk);
        check("basic_z_hold", int'(z), 10);
        check("basic_done_pulse", int'(done), 0);
        check("basic_busy_idle", int'(busy), 0);

        // Extremes
        for (int i = 0; i < 3; i++) begin
            issue(4'(ex_x[i]), 4'(ex_y[i]), 4'(ex_z[i]), 1'b0);
            wait_done(lat, bcnt);
            check("extreme_latency", lat, 9);
            @(negedge clk);
        end

        // Start while busy is ignored: 4*5 = 20 -> 9
        issue(4'd4, 4'd5, 4'd9, 1'b0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        x     = 4'd2;
        y     = 4'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, bcnt);
        check("busy_start_latency", lat, 7);
        repeat (12) @(negedge clk);

        // Back-to-back: 2*9 = 18 -> 7, then 6*6 = 36 -> 3 started in the DONE cycle
        issue(4'd2, 4'd9, 4'd7, 1'b0);
        wait_done(lat, bcnt);
        issue(4'd6, 4'd6, 4'd3, 1'b0);
        wait_done(lat, bcnt);
        check("b2b_latency", lat, 9);
        check("b2b_busy_cycles", bcnt, 8);
        @(negedge clk);

        // Reset mid-operation: no done pulse may follow
        start = 1'b1;
        x     = 4'd3;
        y     = 4'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_z", int'(z), 0);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("midrst_idle_busy", int'(busy), 0);

`ifdef MOD_MULT_RANGE_CHECK_EN
        // Out-of-range operand: done+err one cycle after acceptance
        issue(4'd12, 4'd3, 4'd0, 1'b1);
        wait_done(lat, bcnt);
        check("range_latency", lat, 1);
        check("range_busy_cycles", bcnt, 0);
        @(negedge clk);
        issue(4'd5, 4'd2, 4'd10, 1'b0);
        wait_done(lat, bcnt);
        check("range_ok_latency", lat, 9);
        @(negedge clk);
`endif

        // Exhaustive sweep over all in-range pairs
        m0 = matched;
        for (int i = 0; i < 11; i++) begin
            for (int j = 0; j < 11; j++) begin
                issue(4'(i), 4'(j), 4'((i * j) % 11), 1'b0);
                wait_done(lat, bcnt);
            end
        end
        $display("exhaustive: %0d/121 products matched", matched - m0);

        repeat (3) @(negedge clk);
        check("pending_expectations", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mod_mult_seq
